// File: rtl/alu_pkg.sv
// Shared definitions for the alu_16bit opcode map and the ALU arbiter sequencer.
package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 3;

  localparam logic [ALU_OP_W-1:0] OP_NOT = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_DEC = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b101;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [ALU_OP_W-1:0] OP_INC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The ALU only drives a meaningful carry/borrow for ADD and SUB.
  function automatic logic op_has_cout(input logic [ALU_OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the master that was not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt,
  output logic       gnt_valid
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt = ~last_grant_q;
    else              gnt = req[1];
    last_grant_d = accept ? gnt : last_grant_q;
  end

  // Reset to 1 so master 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_arbiter_2req.sv
// Round-robin arbiter/sequencer in front of a shared combinational 16-bit ALU.
// Optional zero-flag responses are enabled with `define ALU_ARB_ZERO_FLAG_EN.
//
// state | meaning
// IDLE  | waiting for a request; combinational grant drives reqN_ready
// EXEC  | operands held on alu_*; counting settle cycles before capture
// RESP  | rsp<owner>_valid high until the owner asserts rsp_ready
module alu_arbiter_2req
  import alu_pkg::*;
#(
  parameter int DATA_W      = ALU_DATA_W,
  parameter int OP_W        = ALU_OP_W,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_cout,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_cout,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  output logic              busy
`ifdef ALU_ARB_ZERO_FLAG_EN
  ,
  output logic              rsp0_zero,
  output logic              rsp1_zero
`endif
);

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              cout_q, cout_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic              gnt, gnt_valid, accept, capture;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1_valid, req0_valid}),
    .accept    (accept),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign req0_ready = (state_q == IDLE) && gnt_valid && !gnt;
  assign req1_ready = (state_q == IDLE) && gnt_valid &&  gnt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    result_d    = result_q;
    cout_d      = cout_q;
    rsp_valid_d = rsp_valid_q;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          accept   = 1'b1;
          owner_d  = gnt;
          alu_a_d  = gnt ? req1_a  : req0_a;
          alu_b_d  = gnt ? req1_b  : req0_b;
          alu_op_d = gnt ? req1_op : req0_op;
          cnt_d    = 4'd0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == EXEC_LAST) begin
          capture     = 1'b1;
          result_d    = alu_result;
          // Carry is undriven by the ALU for logic/inc/dec ops; mask it here.
          cout_d      = op_has_cout(alu_op_q) ? alu_cout : 1'b0;
          rsp_valid_d = owner_q ? 2'b10 : 2'b01;
          cnt_d       = 4'd0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = result_q;
  assign rsp1_data  = result_q;
  assign rsp0_cout  = cout_q;
  assign rsp1_cout  = cout_q;
  assign busy       = busy_q;

`ifdef ALU_ARB_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = capture ? (alu_result == '0) : zero_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end

  assign rsp0_zero = zero_q;
  assign rsp1_zero = zero_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_arbiter_2req.sv
// Self-checking bench for alu_arbiter_2req: vector table, contention, backpressure, reset mid-op.
module tb_alu_arbiter_2req;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid, req0_valid4, req1_valid4;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_ready, rsp1_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout, busy;
  logic [15:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_cout;

  logic        req0_ready4, req1_ready4, rsp0_valid4, rsp1_valid4, rsp0_cout4, rsp1_cout4, busy4;
  logic [15:0] rsp0_data4, rsp1_data4, alu_a4, alu_b4, alu_result4;
  logic [2:0]  alu_op4;
  logic        alu_cout4;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic rsp0_zero, rsp1_zero, rsp0_zero4, rsp1_zero4;
`endif

  // External ALU model; drives cout=1 for ops whose carry the arbiter must mask.
  function automatic logic [16:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op);
    case (op)
      OP_NOT:  return {1'b1, ~a};
      OP_AND:  return {1'b1, a & b};
      OP_XOR:  return {1'b1, a ^ b};
      OP_OR:   return {1'b1, a | b};
      OP_DEC:  return {1'b1, a - 16'd1};
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), 16'(a - b)};
      default: return {1'b1, a + 16'd1};
    endcase
  endfunction

  always_comb {alu_cout, alu_result}   = alu_model(alu_a, alu_b, alu_op);
  always_comb {alu_cout4, alu_result4} = alu_model(alu_a4, alu_b4, alu_op4);

  alu_arbiter_2req #(.DATA_W(16), .OP_W(3), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_cout(rsp0_cout),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_cout(rsp1_cout),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout), .busy(busy)
`ifdef ALU_ARB_ZERO_FLAG_EN
    , .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero)
`endif
  );

  alu_arbiter_2req #(.DATA_W(16), .OP_W(3), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid4), .req0_ready(req0_ready4), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .rsp0_valid(rsp0_valid4), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data4), .rsp0_cout(rsp0_cout4),
    .req1_valid(req1_valid4), .req1_ready(req1_ready4), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .rsp1_valid(rsp1_valid4), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data4), .rsp1_cout(rsp1_cout4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_result(alu_result4),
    .alu_cout(alu_cout4), .busy(busy4)
`ifdef ALU_ARB_ZERO_FLAG_EN
    , .rsp0_zero(rsp0_zero4), .rsp1_zero(rsp1_zero4)
`endif
  );

  typedef struct {
    logic        m;
    logic [15:0] d;
    logic        c;
    logic        z;
  } exp_t;

  typedef struct {
    logic        m;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] d;
    logic        c;
    logic        z;
  } vec_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic mon(input logic m, input logic [15:0] d, input logic c, input logic z);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_rsp", 32'(m) + 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("rsp_master", 32'(m), 32'(e.m));
      chk("rsp_data", 32'(d), 32'(e.d));
      chk("rsp_cout", 32'(c), 32'(e.c));
`ifdef ALU_ARB_ZERO_FLAG_EN
      chk("rsp_zero", 32'(z), 32'(e.z));
`endif
    end
    chk("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    logic z0, z1;
`ifdef ALU_ARB_ZERO_FLAG_EN
    z0 = rsp0_zero; z1 = rsp1_zero;
`else
    z0 = 1'b0; z1 = 1'b0;
`endif
    if (!rst && rsp0_valid && rsp0_ready) mon(1'b0, rsp0_data, rsp0_cout, z0);
    if (!rst && rsp1_valid && rsp1_ready) mon(1'b1, rsp1_data, rsp1_cout, z1);
  end

  task automatic drive(input logic m, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op);
    if (!m) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else    begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
  endtask

  // Waits for the handshake on master m, pushes the expected response, then drops valid.
  task automatic wait_accept(input logic m, input exp_t e, output logic other_rdy);
    bit done = 0;
    other_rdy = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (m ? req1_ready : req0_ready) begin
        sb.push_back(e);
        other_rdy = m ? req0_ready : req1_ready;
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (!m) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  vec_t vecs[10];
  exp_t cq0[2], cq1[2];
  vec_t cv0[2], cv1[2];

  initial begin
    exp_t e;
    logic orl;
    int   lat;
    bit   seen, done;
    logic g;

    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 16'h1234, 16'h1234, OP_XOR, 16'h0000, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h0000, 16'h0001, OP_SUB, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 16'hF0F0, 16'h0FF0, OP_AND, 16'h00F0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 16'h00FF, 16'h0000, OP_NOT, 16'hFF00, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0001, 16'h0000, OP_DEC, 16'h0000, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 16'hFFFF, 16'h0000, OP_INC, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'h0005, 16'h0003, OP_SUB, 16'h0002, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'h00FF, 16'hFF00, OP_OR,  16'hFFFF, 1'b0, 1'b0};

    cv0[0] = '{1'b0, 16'hF0F0, 16'h0FF0, OP_AND, 16'h00F0, 1'b0, 1'b0};
    cv1[0] = '{1'b1, 16'h00FF, 16'hFF00, OP_OR,  16'hFFFF, 1'b0, 1'b0};
    cv0[1] = '{1'b0, 16'h0001, 16'h0002, OP_ADD, 16'h0003, 1'b0, 1'b0};
    cv1[1] = '{1'b1, 16'hFF00, 16'h0F0F, OP_XOR, 16'hF00F, 1'b0, 1'b0};

    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_valid4 = 0; req1_valid4 = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #12;
    chk("reset_ctrl", {27'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 32'd0);
    chk("reset_alu", {alu_a, alu_b} | 32'(alu_op), 32'd0);
    chk("reset_rsp", {rsp0_data | rsp1_data, 14'd0, rsp0_cout, rsp1_cout}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single-master vectors with latency check (EXEC_CYCLES=1 -> 2 cycles).
    for (int i = 0; i < 10; i++) begin
      e = '{vecs[i].m, vecs[i].d, vecs[i].c, vecs[i].z};
      @(posedge clk); #1;
      drive(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].op);
      wait_accept(vecs[i].m, e, orl);
      chk("single_other_ready", 32'(orl), 32'd0);
      lat = 0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk); lat++;
        if (vecs[i].m ? rsp1_valid : rsp0_valid) done = 1;
      end
      chk("latency", 32'(lat), 32'd2);
      wait_idle();
    end

    // Sustained contention: grants must alternate 0,1,0,1.
    @(posedge clk); #1;
    drive(1'b0, cv0[0].a, cv0[0].b, cv0[0].op);
    drive(1'b1, cv1[0].a, cv1[0].b, cv1[0].op);
    for (int k = 0; k < 4; k++) begin
      done = 0; g = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          done = 1; g = req1_ready;
          chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
          if (k % 2 == 0) sb.push_back('{cv0[k/2].m, cv0[k/2].d, cv0[k/2].c, cv0[k/2].z});
          else            sb.push_back('{cv1[k/2].m, cv1[k/2].d, cv1[k/2].c, cv1[k/2].z});
        end
      end
      chk("contention_grant", 32'(g), 32'(k % 2));
      @(posedge clk); #1;
      if (k % 2 == 0) begin
        if (k / 2 == 0) drive(1'b0, cv0[1].a, cv0[1].b, cv0[1].op); else req0_valid = 1'b0;
      end else begin
        if (k / 2 == 0) drive(1'b1, cv1[1].a, cv1[1].b, cv1[1].op); else req1_valid = 1'b0;
      end
    end
    wait_idle();

    // Response backpressure on master 0 while master 1 waits.
    rsp0_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 16'hFFFF, 16'h1234, OP_AND);
    wait_accept(1'b0, '{1'b0, 16'h1234, 1'b0, 1'b0}, orl);
    drive(1'b1, 16'h0001, 16'h0002, OP_OR);
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (rsp0_valid) done = 1;
    end
    chk("bp_rsp_seen", 32'(done), 32'd1);
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      chk("bp_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_data", 32'(rsp0_data), 32'h1234);
      chk("bp_req1_ready", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    wait_accept(1'b1, '{1'b1, 16'h0003, 1'b0, 1'b0}, orl);
    wait_idle();

    // Reset during EXEC on the EXEC_CYCLES=4 instance.
    @(posedge clk); #1;
    req0_a = 16'h1111; req0_b = 16'h2222; req0_op = OP_ADD; req0_valid4 = 1'b1;
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (req0_ready4) done = 1;
    end
    chk("d4_accept", 32'(done), 32'd1);
    @(posedge clk); #1 req0_valid4 = 1'b0;
    @(posedge clk); #1;
    chk("d4_busy_before_rst", 32'(busy4), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {28'd0, rsp0_valid4, rsp1_valid4, busy4, req0_ready4}, 32'd0);
    chk("rst_mid_alu", {alu_a4, alu_b4} | 32'(alu_op4), 32'd0);
    chk("rst_mid_rsp", {rsp0_data4, 14'd0, rsp0_cout4, rsp1_cout4}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (rsp0_valid4 || rsp1_valid4) seen = 1;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    @(posedge clk); #1;
    req0_a = 16'h0003; req0_b = 16'h0004; req0_op = OP_ADD;
    req1_a = 16'h0000; req1_b = 16'h0000; req1_op = OP_NOT;
    req0_valid4 = 1'b1; req1_valid4 = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", {30'd0, req0_ready4, req1_ready4}, 32'd2);
    @(posedge clk); #1 req0_valid4 = 1'b0;
    lat = 0; done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk); lat++;
      if (rsp0_valid4) done = 1;
    end
    chk("d4_latency", 32'(lat), 32'd5);
    chk("d4_data", 32'(rsp0_data4), 32'h0007);
    done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (req1_ready4) done = 1;
    end
    chk("d4_req1_served", 32'(done), 32'd1);
    @(posedge clk); #1 req1_valid4 = 1'b0;
    done = 0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(negedge clk);
      if (rsp1_valid4) done = 1;
    end
    chk("d4_rsp1_data", 32'(rsp1_data4), 32'hFFFF);
    chk("d4_rsp1_cout", 32'(rsp1_cout4), 32'd0);
    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
